// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline front end.
//   fetch_state_e    : instruction-fetch FSM states
//   NOP_INSTR        : encoding placed in a pipeline register that holds no instruction
//   OPCODE_MSB/LSB   : position of the primary opcode field in an instruction word
//   DEFAULT_RESET_PC : PC loaded on reset unless a block overrides it
package mips_pkg;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,  // issue a request whenever IF/ID can take a new entry
      S_WAIT   = 2'd1,  // request outstanding, memory inserting wait states
      S_HOLD   = 2'd2,  // fetched word parked in the skid register
      S_SQUASH = 2'd3   // finishing a request whose data must be thrown away
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam int          OPCODE_MSB       = 31;
   localparam int          OPCODE_LSB       = 26;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_pipe_reg.sv
// Generic valid/instr/pc4 pipeline register.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   load         : capture load_instr/load_pc4 and mark the entry valid
//   flush        : drop the entry (valid=0, instr=NOP); wins over load
//   load_instr   : instruction to capture
//   load_pc4     : address of that instruction + 4
//   valid/instr/pc4 : registered contents
// With neither load nor flush the entry holds unchanged.
module if_id_pipe_reg
   import mips_pkg::*;
#(
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                flush,
   input  logic [31:0]         load_instr,
   input  logic [PC_WIDTH-1:0] load_pc4,
   output logic                valid,
   output logic [31:0]         instr,
   output logic [PC_WIDTH-1:0] pc4
);

   logic                valid_q, valid_d;
   logic [31:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] pc4_q, pc4_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if (flush) begin
         // pc4 is left alone; it is meaningless once valid is low.
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = load_instr;
         pc4_d   = load_pc4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc4   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the main control decoder.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   imem_req/addr     : fetch request to instruction memory
//   imem_ready/rdata  : memory acceptance and same-cycle read data
//   stall             : downstream cannot take a new IF/ID entry
//   redirect_valid/pc : taken branch/jump, flushes IF/ID and refetches
//   if_id_valid/instr/pc4 : IF/ID pipeline register contents
//   if_opcode         : opcode field of if_id_instr for the decoder
//   dbg_state         : current fetch FSM state
//
// Handshake: imem_req/imem_addr form a request; a transfer happens in any
// cycle where imem_req && imem_ready, with imem_rdata valid in that cycle.
// Once imem_req rises without ready, it stays high with imem_addr stable
// until ready (reset and redirect in S_FETCH are the only exceptions, and
// memory tolerates an abandoned request).
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_rdata,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instr,
   output logic [PC_WIDTH-1:0] if_id_pc4,
   output logic [5:0]          if_opcode,
   output fetch_state_e        dbg_state
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         skid_q, skid_d;
   logic [PC_WIDTH-1:0] saved_target_q, saved_target_d;

   logic                slot_free;
   logic                req_int;
   logic                pipe_load;
   logic                pipe_flush;
   logic [31:0]         pipe_instr;
   logic [PC_WIDTH-1:0] pipe_pc4;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] redirect_target;

   // IF/ID can accept a new entry when empty or when it drains this cycle.
   assign slot_free       = !if_id_valid || !stall;
   assign pc_inc          = pc_q + PC_WIDTH'(4);
   assign redirect_target = redirect_pc & ~PC_WIDTH'(3);

   always_comb begin
      req_int = 1'b0;
      case (state_q)
         S_FETCH:  req_int = slot_free;
         S_WAIT:   req_int = 1'b1;
         S_HOLD:   req_int = 1'b0;
         S_SQUASH: req_int = 1'b1;
         default:  req_int = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      skid_d         = skid_q;
      saved_target_d = saved_target_q;
      pipe_load      = 1'b0;
      pipe_instr     = imem_rdata;
      pipe_pc4       = pc_inc;

      case (state_q)
         S_FETCH: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
            end else if (req_int && imem_ready) begin
               pipe_load = 1'b1;
               pc_d      = pc_inc;
            end else if (req_int) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect_valid) begin
               // The outstanding request must still complete; its data is
               // discarded in S_SQUASH before the new target is fetched.
               saved_target_d = redirect_target;
               state_d        = S_SQUASH;
            end else if (imem_ready) begin
               pc_d = pc_inc;
               if (slot_free) begin
                  pipe_load = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  skid_d  = imem_rdata;
                  state_d = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = S_FETCH;
            end else if (slot_free) begin
               // pc already advanced past the parked word, so pc_q is its pc+4.
               pipe_load  = 1'b1;
               pipe_instr = skid_q;
               pipe_pc4   = pc_q;
               state_d    = S_FETCH;
            end
         end

         S_SQUASH: begin
            if (redirect_valid) begin
               saved_target_d = redirect_target;
               if (imem_ready) begin
                  pc_d    = redirect_target;
                  state_d = S_FETCH;
               end
            end else if (imem_ready) begin
               pc_d    = saved_target_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // A redirect kills the entry; otherwise a drained slot with nothing new
   // behind it empties. A stalled valid entry sees neither and holds.
   assign pipe_flush = redirect_valid || (slot_free && !pipe_load);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_FETCH;
         pc_q           <= RESET_PC;
         skid_q         <= NOP_INSTR;
         saved_target_q <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         skid_q         <= skid_d;
         saved_target_q <= saved_target_d;
      end
   end

   if_id_pipe_reg #(
      .PC_WIDTH (PC_WIDTH)
   ) u_if_id (
      .clk        (clk),
      .reset      (reset),
      .load       (pipe_load),
      .flush      (pipe_flush),
      .load_instr (pipe_instr),
      .load_pc4   (pipe_pc4),
      .valid      (if_id_valid),
      .instr      (if_id_instr),
      .pc4        (if_id_pc4)
   );

   assign imem_req  = req_int && !reset;
   assign imem_addr = pc_q;
   assign if_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
   import mips_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (RESET_PC = 0)
   logic         reset;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_ready;
   logic [31:0]  imem_rdata;
   logic         stall;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         if_id_valid;
   logic [31:0]  if_id_instr;
   logic [31:0]  if_id_pc4;
   logic [5:0]   if_opcode;
   fetch_state_e dbg_state;

   // wrap instance (RESET_PC = 0xFFFF_FFFC)
   logic         w_reset;
   logic         w_req;
   logic [31:0]  w_addr;
   logic         w_ready;
   logic [31:0]  w_rdata;
   logic         w_valid;
   logic [31:0]  w_instr;
   logic [31:0]  w_pc4;
   logic [5:0]   w_opcode;
   fetch_state_e w_state;

   int errors = 0;
   int checks = 0;

   if_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc4      (if_id_pc4),
      .if_opcode      (if_opcode),
      .dbg_state      (dbg_state)
   );

   if_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk            (clk),
      .reset          (w_reset),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_ready     (w_ready),
      .imem_rdata     (w_rdata),
      .stall          (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .if_id_valid    (w_valid),
      .if_id_instr    (w_instr),
      .if_id_pc4      (w_pc4),
      .if_opcode      (w_opcode),
      .dbg_state      (w_state)
   );

   // Instruction memory contents: addi-style word tagged with its address,
   // except address 8 which holds lw $t0, 4($zero).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8) return 32'h8C08_0004;
      return 32'h2000_0000 | a;
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);
   always_comb w_rdata    = mem_word(w_addr);

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_ready     = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_ready     = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL reset_req_low: got %b expected 0", imem_req);
      end
      step();
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL reset_req_low_after_edge: got %b expected 0", imem_req);
      end
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b0, 32'h0, 32'h0}) begin
         errors++; $display("FAIL reset_if_id: got v=%b i=%h p=%h expected 0/0/0",
                            if_id_valid, if_id_instr, if_id_pc4);
      end
      checks++;
      if (imem_addr !== 32'h0 || dbg_state !== S_FETCH) begin
         errors++; $display("FAIL reset_pc_state: got addr=%h st=%0d expected 0/0",
                            imem_addr, dbg_state);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected 1/0",
                            imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_i;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: exp_i = 32'h2000_0000;
            1: exp_i = 32'h2000_0004;
            2: exp_i = 32'h8C08_0004;
            default: exp_i = 32'h2000_000C;
         endcase
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
            errors++; $display("FAIL zw_req[%0d]: got req=%b addr=%h expected 1/%h",
                               i, imem_req, imem_addr, i * 4);
         end
         step();
         checks++;
         if (if_id_valid !== 1'b1 || if_id_instr !== exp_i || if_id_pc4 !== 32'((i + 1) * 4)
             || if_opcode !== exp_i[31:26]) begin
            errors++; $display("FAIL zw_ifid[%0d]: got v=%b i=%h p=%h op=%b expected 1/%h/%h/%b",
                               i, if_id_valid, if_id_instr, if_id_pc4, if_opcode,
                               exp_i, (i + 1) * 4, exp_i[31:26]);
         end
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      step();  // word 0
      step();  // word 4
      imem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) imem_ready = 1'b1;
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL ws_hold_req[%0d]: got req=%b addr=%h expected 1/8",
                               k, imem_req, imem_addr);
         end
         step();
         if (k < 3) begin
            checks++;
            if (if_id_valid !== 1'b0) begin
               errors++; $display("FAIL ws_bubble[%0d]: got valid=%b expected 0", k, if_id_valid);
            end
         end
      end
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C08_0004 || if_opcode !== 6'b100011
          || if_id_pc4 !== 32'hC || imem_addr !== 32'hC) begin
         errors++; $display("FAIL ws_lw: got v=%b i=%h op=%b p=%h addr=%h expected 1/8c080004/100011/c/c",
                            if_id_valid, if_id_instr, if_opcode, if_id_pc4, imem_addr);
      end
   endtask

   task automatic test_stall_wait();
      do_reset();
      for (int i = 0; i < 4; i++) step();
      imem_ready = 1'b0;
      step();
      checks++;
      if (dbg_state !== S_WAIT || imem_addr !== 32'h10) begin
         errors++; $display("FAIL sw_enter_wait: got st=%0d addr=%h expected 1/10", dbg_state, imem_addr);
      end
      imem_ready = 1'b1;
      stall      = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
         errors++; $display("FAIL sw_req_in_wait: got req=%b addr=%h expected 1/10", imem_req, imem_addr);
      end
      step();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2000_0010 || if_id_pc4 !== 32'h14) begin
         errors++; $display("FAIL sw_capture: got v=%b i=%h p=%h expected 1/20000010/14",
                            if_id_valid, if_id_instr, if_id_pc4);
      end
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL sw_req_stalled: got %b expected 0", imem_req);
      end
      step();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2000_0010 || imem_req !== 1'b0) begin
         errors++; $display("FAIL sw_hold: got v=%b i=%h req=%b expected 1/20000010/0",
                            if_id_valid, if_id_instr, imem_req);
      end
      stall = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
         errors++; $display("FAIL sw_resume: got req=%b addr=%h expected 1/14", imem_req, imem_addr);
      end
      step();
      checks++;
      if (if_id_instr !== 32'h2000_0014 || if_id_pc4 !== 32'h18) begin
         errors++; $display("FAIL sw_next: got i=%h p=%h expected 20000014/18", if_id_instr, if_id_pc4);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      for (int i = 0; i < 8; i++) step();
      imem_ready = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || dbg_state !== S_SQUASH) begin
         errors++; $display("FAIL rw_flush: got v=%b i=%h st=%0d expected 0/0/3",
                            if_id_valid, if_id_instr, dbg_state);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
         errors++; $display("FAIL rw_old_req: got req=%b addr=%h expected 1/20", imem_req, imem_addr);
      end
      imem_ready = 1'b1;
      step();
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++; $display("FAIL rw_discard: got v=%b i=%h req=%b addr=%h expected 0/0/1/40",
                            if_id_valid, if_id_instr, imem_req, imem_addr);
      end
      step();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2000_0040 || if_id_pc4 !== 32'h44) begin
         errors++; $display("FAIL rw_target: got v=%b i=%h p=%h expected 1/20000040/44",
                            if_id_valid, if_id_instr, if_id_pc4);
      end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      step();
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL rs_req_stalled: got %b expected 0", imem_req);
      end
      step();
      redirect_valid = 1'b0;
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_opcode !== 6'h0 || imem_addr !== 32'h40) begin
         errors++; $display("FAIL rs_flush: got v=%b i=%h op=%b addr=%h expected 0/0/0/40",
                            if_id_valid, if_id_instr, if_opcode, imem_addr);
      end
      stall = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1) begin
         errors++; $display("FAIL rs_refetch_req: got %b expected 1", imem_req);
      end
      step();
      checks++;
      if (if_id_instr !== 32'h2000_0040 || if_id_pc4 !== 32'h44) begin
         errors++; $display("FAIL rs_target: got i=%h p=%h expected 20000040/44", if_id_instr, if_id_pc4);
      end
   endtask

   task automatic test_wrap_and_reset_mid_wait();
      w_reset = 1'b1;
      w_ready = 1'b1;
      step();
      step();
      w_reset = 1'b0;
      #1;
      checks++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wr_first: got req=%b addr=%h expected 1/fffffffc", w_req, w_addr);
      end
      step();
      checks++;
      if (w_valid !== 1'b1 || w_instr !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_addr !== 32'h0) begin
         errors++; $display("FAIL wr_wrap: got v=%b i=%h p=%h addr=%h expected 1/fffffffc/0/0",
                            w_valid, w_instr, w_pc4, w_addr);
      end
      w_ready = 1'b0;
      step();
      checks++;
      if (w_state !== S_WAIT || w_req !== 1'b1) begin
         errors++; $display("FAIL wr_wait: got st=%0d req=%b expected 1/1", w_state, w_req);
      end
      w_reset = 1'b1;
      #1;
      checks++;
      if (w_req !== 1'b0) begin
         errors++; $display("FAIL wr_reset_req: got %b expected 0", w_req);
      end
      step();
      checks++;
      if (w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0 || w_state !== S_FETCH) begin
         errors++; $display("FAIL wr_reset_pc: got addr=%h v=%b st=%0d expected fffffffc/0/0",
                            w_addr, w_valid, w_state);
      end
      w_reset = 1'b0;
      #1;
      checks++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wr_restart: got req=%b addr=%h expected 1/fffffffc", w_req, w_addr);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_ready     = 1'b0;
      w_reset        = 1'b1;
      w_ready        = 1'b0;

      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_wait();
      test_redirect_wait();
      test_redirect_stall();
      test_wrap_and_reset_mid_wait();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
